shared_reg_arbiter: RTL

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   DEPTH x WIDTH register bank written by NREQ requesters through a
//   round-robin arbiter, read through a single combinational port.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous active-high reset (bank and pointer to 0)
//   clear  : synchronous zeroing of every entry; blocks grants, pointer holds
//   req    : per-requester write request
//   waddr  : per-requester entry index, requester i at [i*AW +: AW]
//   wdata  : per-requester write data,  requester i at [i*WIDTH +: WIDTH]
//   gnt    : one-hot write grant, valid in the current cycle
//   raddr  : read index
//   rdata  : contents of entry raddr (0 for indices >= DEPTH)
//   busy   : some req bit set and the cycle is not a clear cycle
module shared_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    waddr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  input  logic [AW-1:0]         raddr,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [NREQ-1:0]  req_hi;
  logic [NREQ-1:0]  pick_hi;
  logic [NREQ-1:0]  pick_all;
  logic [NREQ-1:0]  gnt_c;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [DEPTH-1:0] we;
  logic [WIDTH-1:0] bank [DEPTH];

  // Round-robin pick: first look only at requesters at or above ptr,
  // otherwise wrap to the lowest requester overall. x & -x isolates
  // the lowest set bit.
  always_comb begin
    req_hi   = req & ~((NREQ'(1) << ptr) - NREQ'(1));
    pick_hi  = req_hi & (~req_hi + NREQ'(1));
    pick_all = req & (~req + NREQ'(1));
    gnt_c    = (req_hi != '0) ? pick_hi : pick_all;
    if (reset || clear) begin
      gnt_c = '0;
    end
  end

  assign gnt  = gnt_c;
  assign busy = (|req) & ~clear & ~reset;

  always_comb begin
    gnt_any = |gnt_c;
    gnt_idx = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) begin
        gnt_idx = PW'(i);
        wr_addr = waddr[i*AW +: AW];
        wr_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // An out-of-range wr_addr matches no entry, so the write is dropped
  // while the grant (and pointer advance) still happens.
  always_comb begin
    we = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      we[e] = gnt_any && (wr_addr == AW'(e));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        bank[e] <= '0;
      end
    end else if (clear) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        bank[e] <= '0;
      end
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (we[e]) begin
          bank[e] <= wr_data;
        end
      end
      if (gnt_any) begin
        ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (raddr == AW'(e)) begin
        rdata = bank[e];
      end
    end
  end

endmodule
